// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio sequencer.
// Pure declarations: no latency, no flow control.
package pwm_audio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      HOLD,
      LAST
   } state_e;

   localparam int PWM_W      = 8;
   localparam int PWM_PERIOD = 256;

   // Width of the sample-rate divider; its terminal count is div-1, which always fits.
   function automatic int div_w(input int div);
      return $clog2(div);
   endfunction

endpackage

// File: rtl/pwm_audio_sequencer_pwm_carrier.sv
// pwm_carrier: free-running 256-clock carrier; duty reloads only at wrap, output is registered.
// Latency: duty visible one clock after the wrap; clr forces the output low on the next clock, no backpressure.
module pwm_carrier
   import pwm_audio_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [PWM_W-1:0] next_duty,
   input  logic             clr,
   output logic             pwm_out
);

   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      duty_d = duty_q;
      // Reloading on the last count keeps every period whole.
      if (cnt_q == PWM_W'(PWM_PERIOD - 1)) begin
         duty_d = next_duty;
      end
      if (clr) begin
         duty_d = '0;
      end
      pwm_d = (cnt_q < duty_q) && !clr;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q  <= '0;
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_audio_sequencer.sv
// pwm_audio_sequencer: plays an 8-bit clip from sync-read memory through a PWM carrier; VOLUME_SCALE_EN adds vol_shift_in.
// Latency: read issued 1 clock after each sample tick, duty applied at next carrier wrap; no backpressure (memory answers in 1 clock).
module pwm_audio_sequencer
   import pwm_audio_pkg::*;
#(
   parameter int SAMPLE_DIV = 2268,
   parameter int ADDR_W     = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic              stop_in,
   input  logic              loop_in,
   input  logic [ADDR_W-1:0] start_addr_in,
   input  logic [ADDR_W-1:0] end_addr_in,
`ifdef VOLUME_SCALE_EN
   input  logic [2:0]        vol_shift_in,
`endif
   output logic              mem_rd_en_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   input  logic [7:0]        mem_data_in,
   output logic              pwm_out,
   output logic              busy_out,
   output logic              done_out
);

   localparam int DIV_W = div_w(SAMPLE_DIV);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [PWM_W-1:0]  pending_q, pending_d;
   logic [PWM_W-1:0]  next_duty_q, next_duty_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [PWM_W-1:0]  duty_new;
   logic              tick;
   logic              rd_en;
   logic              done;
   logic              carrier_clr;

   assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      start_d     = start_q;
      end_d       = end_q;
      pending_d   = pending_q;
      next_duty_d = next_duty_q;
      div_d       = '0;
      rd_en       = 1'b0;
      done        = 1'b0;
      carrier_clr = 1'b0;
      duty_new    = pending_q;
`ifdef VOLUME_SCALE_EN
      duty_new = pending_q >> vol_shift_in;
`endif

      if (state_q != IDLE) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start_in && !stop_in) begin
               start_d = start_addr_in;
               end_d   = end_addr_in;
               addr_d  = start_addr_in;
               state_d = FETCH;
            end
         end
         FETCH: begin
            rd_en   = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            pending_d = mem_data_in;
            state_d   = HOLD;
         end
         HOLD: begin
            if (tick) begin
               next_duty_d = duty_new;
               if (addr_q != end_q) begin
                  addr_d  = addr_q + 1'b1;
                  state_d = FETCH;
               end else if (loop_in) begin
                  addr_d  = start_q;
                  state_d = FETCH;
               end else begin
                  state_d = LAST;
               end
            end
         end
         LAST: begin
            // The final sample still gets its full period before the clip ends.
            if (tick) begin
               done        = 1'b1;
               next_duty_d = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (stop_in && (state_q != IDLE)) begin
         state_d     = IDLE;
         next_duty_d = '0;
         done        = 1'b0;
         carrier_clr = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         start_q     <= '0;
         end_q       <= '0;
         pending_q   <= '0;
         next_duty_q <= '0;
         div_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         start_q     <= start_d;
         end_q       <= end_d;
         pending_q   <= pending_d;
         next_duty_q <= next_duty_d;
         div_q       <= div_d;
      end
   end

   pwm_carrier u_carrier (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .next_duty (next_duty_q),
      .clr       (carrier_clr),
      .pwm_out   (pwm_out)
   );

   assign mem_rd_en_out = rd_en;
   assign mem_addr_out  = addr_q;
   assign busy_out      = (state_q != IDLE);
   assign done_out      = done;

endmodule
